// File: rtl/float_point_addsub.sv
// Multi-cycle IEEE-754-style adder/subtractor: capture, align, add, normalise, round, deliver.
// Fixed five-cycle latency from accept to the sum_ready pulse, with back-to-back accepts in DONE.
module float_point_addsub #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [EXP_LEN+MANTISSA_LEN:0]     a,
    input  logic [EXP_LEN+MANTISSA_LEN:0]     b,
    input  logic                              op_sub,
    input  logic                              inp_data_ready,
    output logic                              in_ready,
    output logic [EXP_LEN+MANTISSA_LEN:0]     sum,
    output logic                              sum_ready,
    output logic                              overflow,
    output logic                              invalid
);
    localparam int W = 1 + EXP_LEN + MANTISSA_LEN;
    localparam int M = MANTISSA_LEN;
    localparam int F = M + 4;  // hidden, fraction, guard, round, sticky

    localparam logic [EXP_LEN-1:0] EXP_ONE   = {{(EXP_LEN-1){1'b0}}, 1'b1};
    localparam logic [EXP_LEN:0]   EXPX_ONE  = {{EXP_LEN{1'b0}}, 1'b1};
    localparam logic [EXP_LEN:0]   EXPX_MAX  = {1'b0, {EXP_LEN{1'b1}}};
    localparam logic [W-1:0]       QNAN      = {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(M-1){1'b0}}};
    localparam logic [W-2:0]       INF_MAG   = {{EXP_LEN{1'b1}}, {M{1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state_reg, state_next;

    logic accept;
    assign in_ready = (state_reg == IDLE) || (state_reg == DONE);
    assign accept   = inp_data_ready && in_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    state_next = accept ? ALIGN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Captured operands and their classification
    logic               sign_a_reg, sign_b_reg;
    logic [EXP_LEN-1:0] exp_a_reg, exp_b_reg;
    logic [M:0]         man_a_reg, man_b_reg;
    logic               nan_a_reg, nan_b_reg, inf_a_reg, inf_b_reg;

    logic [EXP_LEN-1:0] ea, eb;
    logic [M-1:0]       fa, fb;
    assign ea = a[W-2:M];
    assign eb = b[W-2:M];
    assign fa = a[M-1:0];
    assign fb = b[M-1:0];

    // Alignment
    logic               a_big;
    logic [EXP_LEN-1:0] big_exp, small_exp, diff;
    logic [M:0]         small_man;
    logic [F-1:0]       big_ext, small_ext, small_shifted, aligned;
    logic               lost;

    always_comb begin
        a_big     = (exp_a_reg > exp_b_reg) ||
                    ((exp_a_reg == exp_b_reg) && (man_a_reg >= man_b_reg));
        big_exp   = a_big ? exp_a_reg : exp_b_reg;
        small_exp = a_big ? exp_b_reg : exp_a_reg;
        small_man = a_big ? man_b_reg : man_a_reg;
        big_ext   = {(a_big ? man_a_reg : man_b_reg), 3'b000};
        small_ext = {small_man, 3'b000};
        diff      = big_exp - small_exp;
        small_shifted = small_ext >> diff;
        lost      = |(small_ext & ~({F{1'b1}} << diff));
        if (32'(diff) > 32'(F - 1))
            aligned = {{(F-1){1'b0}}, |small_man};
        else
            aligned = {small_shifted[F-1:1], small_shifted[0] | lost};
    end

    logic               big_sign_reg, small_sign_reg;
    logic [EXP_LEN-1:0] big_exp_reg;
    logic [F-1:0]       big_f_reg, small_f_reg;

    // Magnitude add / subtract
    logic       eff_sub;
    logic [F:0] add_m;
    assign eff_sub = big_sign_reg ^ small_sign_reg;
    assign add_m   = eff_sub ? ({1'b0, big_f_reg} - {1'b0, small_f_reg})
                             : ({1'b0, big_f_reg} + {1'b0, small_f_reg});

    logic               add_sign_reg;
    logic [EXP_LEN-1:0] add_exp_reg;
    logic [F:0]         add_m_reg;

    function automatic int count_lz(input logic [F-1:0] v);
        int n;
        n = F;
        for (int i = 0; i < F; i++)
            if (v[i]) n = F - 1 - i;
        return n;
    endfunction

    // Normalisation; the left shift is capped so the exponent never drops below 1
    int           lz, limit, shamt;
    logic [F-1:0] shifted, norm_f;
    logic [EXP_LEN:0] norm_exp;

    always_comb begin
        lz       = 0;
        limit    = 0;
        shamt    = 0;
        shifted  = '0;
        norm_f   = '0;
        norm_exp = '0;
        if (add_m_reg[F]) begin
            norm_f   = {add_m_reg[F:2], add_m_reg[1] | add_m_reg[0]};
            norm_exp = {1'b0, add_exp_reg} + EXPX_ONE;
        end else begin
            lz       = count_lz(add_m_reg[F-1:0]);
            limit    = int'(add_exp_reg) - 1;
            shamt    = (lz < limit) ? lz : limit;
            shifted  = add_m_reg[F-1:0] << shamt;
            norm_f   = shifted;
            norm_exp = shifted[F-1] ? ({1'b0, add_exp_reg} - (EXP_LEN+1)'(shamt)) : '0;
        end
    end

    logic             norm_sign_reg;
    logic [F-1:0]     norm_f_reg;
    logic [EXP_LEN:0] norm_exp_reg;

    // Rounding and special-case override
    logic             inc;
    logic [M+1:0]     rnd_m;
    logic [EXP_LEN:0] fin_exp;
    logic [M-1:0]     fin_frac;
    logic [W-1:0]     rnd_sum;
    logic             rnd_ovf, rnd_inv;

    always_comb begin
        inc     = norm_f_reg[2] & (norm_f_reg[1] | norm_f_reg[0] | norm_f_reg[3]);
        rnd_m   = {1'b0, norm_f_reg[F-1:3]} + {{(M+1){1'b0}}, inc};
        rnd_ovf = 1'b0;
        rnd_inv = 1'b0;
        if (rnd_m[M+1]) begin
            fin_exp  = norm_exp_reg + EXPX_ONE;
            fin_frac = rnd_m[M:1];
        end else if ((norm_exp_reg == '0) && rnd_m[M]) begin
            fin_exp  = EXPX_ONE;  // subnormal rounded up into the smallest normal
            fin_frac = rnd_m[M-1:0];
        end else begin
            fin_exp  = norm_exp_reg;
            fin_frac = rnd_m[M-1:0];
        end
        rnd_sum = {norm_sign_reg, fin_exp[EXP_LEN-1:0], fin_frac};
        if (nan_a_reg || nan_b_reg) begin
            rnd_sum = QNAN;
            rnd_inv = 1'b1;
        end else if (inf_a_reg && inf_b_reg && (sign_a_reg != sign_b_reg)) begin
            rnd_sum = QNAN;
            rnd_inv = 1'b1;
        end else if (inf_a_reg) begin
            rnd_sum = {sign_a_reg, INF_MAG};
        end else if (inf_b_reg) begin
            rnd_sum = {sign_b_reg, INF_MAG};
        end else if (fin_exp >= EXPX_MAX) begin
            rnd_sum = {norm_sign_reg, INF_MAG};
            rnd_ovf = 1'b1;
        end
    end

    logic [W-1:0] res_sum_reg;
    logic         res_ovf_reg, res_inv_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            sign_a_reg     <= 1'b0;
            sign_b_reg     <= 1'b0;
            exp_a_reg      <= '0;
            exp_b_reg      <= '0;
            man_a_reg      <= '0;
            man_b_reg      <= '0;
            nan_a_reg      <= 1'b0;
            nan_b_reg      <= 1'b0;
            inf_a_reg      <= 1'b0;
            inf_b_reg      <= 1'b0;
            big_sign_reg   <= 1'b0;
            small_sign_reg <= 1'b0;
            big_exp_reg    <= '0;
            big_f_reg      <= '0;
            small_f_reg    <= '0;
            add_sign_reg   <= 1'b0;
            add_exp_reg    <= '0;
            add_m_reg      <= '0;
            norm_sign_reg  <= 1'b0;
            norm_f_reg     <= '0;
            norm_exp_reg   <= '0;
            res_sum_reg    <= '0;
            res_ovf_reg    <= 1'b0;
            res_inv_reg    <= 1'b0;
            sum            <= '0;
            sum_ready      <= 1'b0;
            overflow       <= 1'b0;
            invalid        <= 1'b0;
        end else begin
            state_reg <= state_next;
            sum_ready <= 1'b0;
            if (accept) begin
                sign_a_reg <= a[W-1];
                sign_b_reg <= b[W-1] ^ op_sub;
                exp_a_reg  <= (ea == '0) ? EXP_ONE : ea;
                exp_b_reg  <= (eb == '0) ? EXP_ONE : eb;
                man_a_reg  <= {ea != '0, fa};
                man_b_reg  <= {eb != '0, fb};
                nan_a_reg  <= (ea == '1) && (fa != '0);
                nan_b_reg  <= (eb == '1) && (fb != '0);
                inf_a_reg  <= (ea == '1) && (fa == '0);
                inf_b_reg  <= (eb == '1) && (fb == '0);
            end
            case (state_reg)
                ALIGN: begin
                    big_sign_reg   <= a_big ? sign_a_reg : sign_b_reg;
                    small_sign_reg <= a_big ? sign_b_reg : sign_a_reg;
                    big_exp_reg    <= big_exp;
                    big_f_reg      <= big_ext;
                    small_f_reg    <= aligned;
                end
                ADD: begin
                    // exact cancellation always yields +0
                    add_sign_reg <= (eff_sub && (add_m == '0)) ? 1'b0 : big_sign_reg;
                    add_exp_reg  <= big_exp_reg;
                    add_m_reg    <= add_m;
                end
                NORM: begin
                    norm_sign_reg <= add_sign_reg;
                    norm_f_reg    <= norm_f;
                    norm_exp_reg  <= norm_exp;
                end
                ROUND: begin
                    res_sum_reg <= rnd_sum;
                    res_ovf_reg <= rnd_ovf;
                    res_inv_reg <= rnd_inv;
                end
                DONE: begin
                    sum       <= res_sum_reg;
                    overflow  <= res_ovf_reg;
                    invalid   <= res_inv_reg;
                    sum_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/float_point_addsub.md
# float_point_addsub

Parametrised, fully IEEE-754-style floating-point adder/subtractor that supersedes the original adder FSM. It adds support for a runtime subtract mode, subnormal operands and results, infinities, NaN, round-to-nearest-even with guard/round/sticky bits, a two-sided valid/ready handshake, and exception flags. The latency is fixed. The block serves as the scalar add engine for the floating-point datapath of the crypto arithmetic units.

## Interface

**Parameters**
- `EXP_LEN`, default 8: exponent field width, ≥ 3.
- `MANTISSA_LEN`, default 23: stored fraction width, ≥ 2. The operand width is W = 1 + EXP_LEN + MANTISSA_LEN.

**Ports**
- `clk` input, 1: the single clock. All state updates on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `a` input, W: operand A as {sign, exponent, fraction}.
- `b` input, W: operand B, same format.
- `op_sub` input, 1: 1 computes a − b (B's sign inverted at capture); 0 computes a + b.
- `inp_data_ready` input, 1: input valid.
- `in_ready` output, 1: block can accept. Combinational from state.
- `sum` output, W: result, registered, held until the next result.
- `sum_ready` output, 1: one-cycle result-valid pulse.
- `overflow` output, 1: result rounded to ±infinity from finite operands. Valid with `sum_ready`.
- `invalid` output, 1: NaN produced. Valid with `sum_ready`.

## Operation

**States:** IDLE → ALIGN → ADD → NORM → ROUND → DONE → IDLE (or ALIGN).

**Handshake**
- Accept when `inp_data_ready && in_ready` at a rising edge.
- `in_ready` = 1 in IDLE and DONE, and 0 otherwise.
- Accepting in DONE goes directly to ALIGN, giving back-to-back operation.

**Capture (at accept)**
- Unpack a and b. B's sign is XOR `op_sub`.
- Exponent 0 gives hidden bit 0 and effective exponent 1 (subnormal or zero).
- Otherwise the hidden bit is 1.
- Classify each operand as zero, subnormal, normal, inf (exponent all ones, fraction 0) or NaN (exponent all ones, fraction ≠ 0).

**ALIGN**
- Select the larger-magnitude operand: compare exponent, then mantissa. On a tie, A is selected.
- Right-shift the smaller mantissa by the exponent difference into a (MANTISSA_LEN+4)-bit field: hidden bit, fraction, guard, round, sticky.
- Bits shifted past the round bit are ORed into sticky.
- Shift amounts > MANTISSA_LEN+3 saturate: mantissa becomes 0, sticky = (mantissa ≠ 0).

**ADD**
- If the effective signs are equal, add the magnitudes (one carry bit).
- Otherwise subtract smaller from larger.
- The result sign is the sign of the larger operand.

**NORM**
- On carry out: shift right 1, OR the lost bit into sticky, exponent + 1.
- Otherwise: a one-cycle leading-zero count, then left shift by min(lzc, exponent − 1). If this limit applies, the result is subnormal and the stored exponent is 0.

**ROUND**
- Round to nearest, ties to even: increment if G & (R | S | LSB).
- If mantissa overflow occurs on rounding, renormalise and exponent + 1.
- If the exponent reaches all ones, the result is ±inf and `overflow` = 1.

**Special results** (these override the datapath; latency is unchanged)
- Any NaN input gives the canonical NaN: sign 0, exponent all ones, fraction MSB 1, rest 0.
- inf + (−inf) gives canonical NaN with `invalid` = 1.
- inf ± finite gives that inf.
- An exact zero from unlike signs gives +0.
- (−0) + (−0) gives −0.
- `overflow` and `invalid` are never both 1.

**DONE**
- Register `sum`, `overflow` and `invalid`; assert `sum_ready`.

## Timing

**Reset**
- While `rst` = 1 and after release: state IDLE, `in_ready` = 1, `sum` = 0, `sum_ready` = 0, `overflow` = 0, `invalid` = 0.
- Reset mid-operation aborts the operation. No `sum_ready` is issued for the aborted operand.

**Latency and throughput**
- Accept at edge T. `sum_ready` goes high after edge T+5 and stays high for exactly one cycle.
- Maximum throughput is one result per 5 cycles with back-to-back accepts in DONE.
- `inp_data_ready` while busy is ignored. Operands must not be assumed held; the block captures them at accept.
- `a`, `b` and `op_sub` are sampled only at the accept edge. Changes afterwards do not affect the result in flight.

## Test plan

- **Basic add and subtract** (EXP_LEN=8, MANTISSA_LEN=23):
  - 0x3F800000 + 0x3F800000 → `sum` 0x40000000, `sum_ready` exactly 5 cycles after accept, flags 0.
  - 0x3F800000 with `op_sub`=1 and b=0x3F800000 → 0x00000000.
- **Rounding ties:**
  - 0x3F800000 + 0x33800000 → 0x3F800000 (tie, rounds to even).
  - 0x3F800001 + 0x33800000 → 0x3F800002.
- **Subnormals:**
  - 0x00000001 + 0x00000001 → 0x00000002.
  - 0x00800000 with `op_sub`=1 and b=0x007FFFFF → 0x00000001.
  - 0x00400000 + 0x00400000 → 0x00800000 (subnormal promotes to normal).
- **Exceptions:**
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, `overflow` = 1.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, `invalid` = 1.
  - 0x7FC00001 + 0x3F800000 → 0x7FC00000.
- **Handshake:**
  - Hold `inp_data_ready` = 1 with a new operand pair each cycle → accepts occur every 5 cycles, each result matches its captured operands, and no pulses are lost.
- **Reset mid-operation:**
  - Assert `rst` 2 cycles after accept → no `sum_ready`, all outputs 0, `in_ready` = 1.
  - Next operation 0x40000000 + 0xC0000000 → 0x00000000.
